sd_spi_master: RTL and testbench
================================

# sd_spi_master

Byte-oriented SPI mode-0 master that physically drives the SD card bus on behalf of `sd_card_cmd`. It accepts one byte per request, shifts it out MSB-first on MOSI while shifting in MISO, and returns the received byte with a one-cycle acknowledge. It also registers the command FSM's chip-select, and its clock rate is set per transfer by the divider the FSM supplies.

## Interface
Parameters:
- none. Widths are fixed: 16-bit divider, 8-bit data.

Ports:
- `sys_clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `nCS_ctrl` in 1: chip-select request from the command FSM (low = select).
- `clk_div` in 16: SCLK half-period minus one, in `sys_clk` cycles.
- `wr_req` in 1: byte transfer request. Level, held until ack.
- `data_in` in 8: byte to transmit. Sampled only at transfer start.
- `wr_ack` out 1: one-cycle pulse marking transfer complete.
- `data_out` out 8: last received byte.
- `spi_sclk` out 1: SD clock.
- `spi_mosi` out 1: SD data in.
- `spi_miso` in 1: SD data out.
- `spi_cs_n` out 1: SD chip select.

## Operation
States are IDLE, SHIFT, ACK and GAP.
- **IDLE**
  - If `wr_req`=1: latch `data_in` into `tx_sh` and latch `clk_div` into `div_q`. Clear the half-period counter `hcnt` and edge counter `ecnt`. Go to SHIFT.
  - `spi_mosi` drives `tx_sh[7]` from the first SHIFT cycle.
- **SHIFT**
  - `hcnt` counts 0..`div_q`. At `hcnt`==`div_q`, `hcnt` resets and an edge event fires: toggle `spi_sclk` and increment `ecnt` (4 bits).
  - Rising edge event (`sclk` 0→1): `rx_sh <= {rx_sh[6:0], spi_miso}`.
  - Falling edge event (`sclk` 1→0): `tx_sh <= {tx_sh[6:0], 1'b1}`.
  - After the 16th edge event (`ecnt` wraps 15→0), `spi_sclk` is low. Go to ACK and load `data_out <= rx_sh` including the final sampled bit.
- **ACK**
  - `wr_ack`=1 for exactly this cycle. Go to GAP.
- **GAP**
  - One idle cycle, then IDLE. `wr_req` is ignored here, so the requester has time to update `data_in` or drop `wr_req` after seeing ack.
  - This gap is mandatory. The command FSM updates `send_data` the cycle after ack.
- **Idle line levels**
  - `spi_mosi`=1 outside SHIFT, so the bus idles high.
- **Chip select**
  - `spi_cs_n <= nCS_ctrl` every cycle, independent of state (one-cycle register).
  - CS changes mid-byte are not blocked. The FSM never does this.
- **Divider arithmetic**
  - Half period = `div_q`+1 cycles. `clk_div`=0 gives `sys_clk`/2, and 16'hFFFF gives `sys_clk`/131072.
  - Compare is equality only, with no overflow.
  - A `clk_div` change during SHIFT has no effect until the next IDLE latch.
- **Reset**, asynchronous, any state including mid-byte:
  - state=IDLE, `spi_sclk`=0, `spi_mosi`=1, `spi_cs_n`=1, `wr_ack`=0, `data_out`=8'h00.
  - Internal registers: `tx_sh`=8'hFF, `rx_sh`=0, counters=0.
  - A partially shifted byte is discarded and no ack is produced.

## Timing
- Request accepted at cycle t (IDLE, `wr_req`=1). Ack is asserted at cycle t+1+16·(D+1), where D=`clk_div`.
- Consequently, back-to-back bytes start every 16·(D+1)+3 cycles.
- `data_out` is valid from the ACK cycle. It holds until the next ACK.
- MISO is sampled at the `sys_clk` edge that raises SCLK. MOSI changes at the edge that lowers SCLK, so data is stable a full half period before each rising edge.

## Configuration
- `SD_SPI_MISO_SYNC_EN` defined:
  - `spi_miso` passes through a 2-flop synchronizer before sampling.
  - Sampling moves to 2 cycles after the rising edge event, still inside SHIFT.
  - The effective D is clamped to ≥2, i.e. `div_q` = max(`clk_div`,2).
- Undefined: MISO is sampled directly, with no clamp.

## Structure
- Package `sd_spi_pkg` holds:
  - state enum `sd_spi_state_t` (IDLE, SHIFT, ACK, GAP);
  - constants `SD_SPI_BITS`=8, `SD_SPI_EDGES`=16 and `SD_SPI_DIV_W`=16;
  - `SD_SPI_IDLE_MOSI`=1'b1.
- One sub-module, `sd_spi_tick`. It holds the 16-bit half-period counter, takes `div_q` and an enable, and emits a one-cycle `edge` pulse. The FSM and shift registers stay in `sd_spi_master`.

## Test plan
- **Loopback, fast clock.** `clk_div`=0, MISO tied to MOSI, send 8'hA5 → `wr_ack` at cycle t+17, `data_out`=8'hA5, and exactly 8 SCLK pulses with period 2.
- **Divider.** `clk_div`=3, send 8'h40 → ack at t+65, SCLK high/low 4 cycles each, and the MOSI bit sequence is 0,1,0,0,0,0,0,0.
- **Receive.** Slave model returns 8'h01 while the master sends 8'hFF → `data_out`=8'h01 and MOSI stays high throughout.
- **Held request.** Keep `wr_req` high across ack and change `data_in` the cycle after ack → the next byte transmits the new value and the start is exactly 3 cycles after the ack cycle.
- **Reset mid-byte.** Assert `rst` at edge 9 of the 16 → immediate SCLK=0, MOSI=1, CS_n=1, `data_out`=0, and no ack.
- **CS and divider latch.** Toggle `nCS_ctrl` and change `clk_div` from 0 to 7 during SHIFT → `spi_cs_n` follows one cycle later and the current byte keeps its half period of 1.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI byte master.
// SD_SPI_MISO_SYNC_EN selects the synchronised-MISO build, which clamps the divider to at least 2.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ACK   = 2'd2,
    S_GAP   = 2'd3
  } sd_spi_state_t;

  localparam int SD_SPI_BITS  = 8;
  localparam int SD_SPI_EDGES = 16;
  localparam int SD_SPI_DIV_W = 16;

  localparam logic SD_SPI_IDLE_MOSI = 1'b1;

  // The synchroniser needs two cycles after each rising edge, so half periods shorter than 3 are not allowed.
  function automatic logic [SD_SPI_DIV_W-1:0] sd_spi_div_eff(input logic [SD_SPI_DIV_W-1:0] div);
`ifdef SD_SPI_MISO_SYNC_EN
    if (div < 16'd2) begin
      return 16'd2;
    end else begin
      return div;
    end
`else
    return div;
`endif
  endfunction

endpackage

// File: rtl/sd_spi_tick.sv
// Half-period counter for the SPI master: emits one edge pulse every div_q+1 enabled cycles.
module sd_spi_tick
  import sd_spi_pkg::*;
(
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [SD_SPI_DIV_W-1:0] div_q,
  output logic                    edge_pulse
);

  logic [SD_SPI_DIV_W-1:0] hcnt_r;

  assign edge_pulse = en && (hcnt_r == div_q);

  // Counter restarts from zero whenever it is disabled or reaches the divider value.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hcnt_r <= 16'd0;
    end else if (!en) begin
      hcnt_r <= 16'd0;
    end else if (hcnt_r == div_q) begin
      hcnt_r <= 16'd0;
    end else begin
      hcnt_r <= hcnt_r + 16'd1;
    end
  end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte master for the SD card bus: one byte per request, MSB first, with a one-cycle ack.
// Build option SD_SPI_MISO_SYNC_EN routes MISO through a 2-flop synchroniser with delayed sampling.
module sd_spi_master
  import sd_spi_pkg::*;
(
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    nCS_ctrl,
  input  logic [SD_SPI_DIV_W-1:0] clk_div,
  input  logic                    wr_req,
  input  logic [SD_SPI_BITS-1:0]  data_in,
  output logic                    wr_ack,
  output logic [SD_SPI_BITS-1:0]  data_out,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic                    spi_cs_n
);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_SHIFT = S_SHIFT;
  localparam logic [1:0] ST_ACK   = S_ACK;
  localparam logic [1:0] ST_GAP   = S_GAP;

  logic [1:0]              state_r;
  logic [SD_SPI_DIV_W-1:0] div_q_r;
  logic [SD_SPI_BITS-1:0]  tx_sh_r;
  logic [SD_SPI_BITS-1:0]  rx_sh_r;
  logic [3:0]              ecnt_r;
  logic                    sclk_r;
  logic                    mosi_r;
  logic                    cs_n_r;
  logic                    ack_r;
  logic [SD_SPI_BITS-1:0]  data_out_r;
  logic                    edge_s;
  logic                    shift_en_s;

  assign shift_en_s = (state_r == ST_SHIFT);

  sd_spi_tick u_tick (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .en         (shift_en_s),
    .div_q      (div_q_r),
    .edge_pulse (edge_s)
  );

`ifdef SD_SPI_MISO_SYNC_EN
  logic       miso_meta_r;
  logic       miso_sync_r;
  logic [1:0] samp_dly_r;

  // Two-flop MISO synchroniser plus a two-cycle delay line marking when the synced bit is due.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
      samp_dly_r  <= 2'b00;
    end else begin
      miso_meta_r <= spi_miso;
      miso_sync_r <= miso_meta_r;
      if (shift_en_s) begin
        samp_dly_r <= {samp_dly_r[0], edge_s & ~sclk_r};
      end else begin
        samp_dly_r <= 2'b00;
      end
    end
  end
`endif

  // Transfer FSM, shift registers and all registered bus outputs.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      div_q_r    <= 16'd0;
      tx_sh_r    <= 8'hFF;
      rx_sh_r    <= 8'h00;
      ecnt_r     <= 4'd0;
      sclk_r     <= 1'b0;
      mosi_r     <= SD_SPI_IDLE_MOSI;
      cs_n_r     <= 1'b1;
      ack_r      <= 1'b0;
      data_out_r <= 8'h00;
    end else begin
      cs_n_r <= nCS_ctrl;
      ack_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wr_req) begin
            tx_sh_r <= data_in;
            div_q_r <= sd_spi_div_eff(clk_div);
            ecnt_r  <= 4'd0;
            sclk_r  <= 1'b0;
            mosi_r  <= data_in[SD_SPI_BITS-1];
            state_r <= ST_SHIFT;
          end else begin
            mosi_r  <= SD_SPI_IDLE_MOSI;
          end
        end
        ST_SHIFT: begin
`ifdef SD_SPI_MISO_SYNC_EN
          if (samp_dly_r[1]) begin
            rx_sh_r <= {rx_sh_r[SD_SPI_BITS-2:0], miso_sync_r};
          end
`endif
          if (edge_s) begin
            sclk_r <= ~sclk_r;
            ecnt_r <= ecnt_r + 4'd1;
            if (!sclk_r) begin
`ifndef SD_SPI_MISO_SYNC_EN
              rx_sh_r <= {rx_sh_r[SD_SPI_BITS-2:0], spi_miso};
`endif
            end else begin
              tx_sh_r <= {tx_sh_r[SD_SPI_BITS-2:0], 1'b1};
              // Last falling edge ends the byte; the final bit was captured on the preceding rise.
              if (ecnt_r == 4'(SD_SPI_EDGES - 1)) begin
                state_r    <= ST_ACK;
                ack_r      <= 1'b1;
                data_out_r <= rx_sh_r;
                mosi_r     <= SD_SPI_IDLE_MOSI;
              end else begin
                mosi_r     <= tx_sh_r[SD_SPI_BITS-2];
              end
            end
          end
        end
        ST_ACK: begin
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_ack   = ack_r;
  assign data_out = data_out_r;
  assign spi_sclk = sclk_r;
  assign spi_mosi = mosi_r;
  assign spi_cs_n = cs_n_r;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed self-checking bench for sd_spi_master (default build, SD_SPI_MISO_SYNC_EN undefined).
module tb_sd_spi_master;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        nCS_ctrl;
  logic [15:0] clk_div;
  logic        wr_req;
  logic [7:0]  data_in;
  logic        wr_ack;
  logic [7:0]  data_out;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;

  logic        loopback;
  logic [7:0]  slave_val;
  logic [3:0]  fall_cnt;
  logic        slave_bit;

  int errors = 0;
  int checks = 0;

  sd_spi_master dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .nCS_ctrl (nCS_ctrl),
    .clk_div  (clk_div),
    .wr_req   (wr_req),
    .data_in  (data_in),
    .wr_ack   (wr_ack),
    .data_out (data_out),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 sys_clk = ~sys_clk;

  // Mode-0 slave: presents slave_val MSB first, advancing on each falling SCLK; restarts per byte.
  always @(negedge spi_sclk or posedge wr_ack or posedge rst) begin
    if (rst || wr_ack) fall_cnt <= 4'd0;
    else               fall_cnt <= fall_cnt + 4'd1;
  end

  assign slave_bit = (fall_cnt < 4'd8) ? slave_val[3'd7 - fall_cnt[2:0]] : 1'b1;
  assign spi_miso  = loopback ? spi_mosi : slave_bit;

  task automatic run_byte(input logic [7:0] d, input logic [15:0] div, input bit cs_mode,
                          output int ack_n, output int ack_cycles, output int rises,
                          output int bad_runs, output logic [7:0] mosi_bits,
                          output bit mosi_low, output logic [2:0] cs_obs);
    int   run_len;
    int   budget;
    logic prev;
    ack_n = 0; ack_cycles = 0; rises = 0; bad_runs = 0;
    mosi_bits = 8'h00; mosi_low = 1'b0; cs_obs = 3'b000;
    budget = 16 * (int'(div) + 1) + 40;
    @(negedge sys_clk);
    data_in = d; clk_div = div; wr_req = 1'b1;
    @(posedge sys_clk);
    prev = 1'b0; run_len = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge sys_clk);
      if (ack_n == 0) begin
        if (spi_sclk !== prev) begin
          if (run_len != int'(div) + 1) bad_runs++;
          run_len = 0;
          if (spi_sclk === 1'b1) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], spi_mosi};
          end
          prev = spi_sclk;
        end
        run_len++;
        if (spi_mosi === 1'b0) mosi_low = 1'b1;
      end
      if (wr_ack === 1'b1) begin
        ack_cycles++;
        if (ack_n == 0) begin
          ack_n  = n;
          wr_req = 1'b0;
        end
      end
      if (cs_mode) begin
        if (n == 4) begin
          cs_obs[0] = spi_cs_n;
          nCS_ctrl  = 1'b1;
          clk_div   = 16'd7;
        end
        if (n == 5) cs_obs[1] = spi_cs_n;
        if (n == 6) nCS_ctrl = 1'b0;
        if (n == 7) cs_obs[2] = spi_cs_n;
      end
      if (ack_n != 0 && n >= ack_n + 2) break;
    end
    wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; nCS_ctrl = 1'b0; wr_req = 1'b0; clk_div = 16'd0; data_in = 8'h00;
    loopback = 1'b1; slave_val = 8'h00;
    #1;
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi: got %b want 1", spi_mosi); end
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", wr_ack); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL reset_cs_follow: got %b want 0", spi_cs_n); end
  endtask

  task automatic test_loopback();
    int ack_n, ack_cycles, rises, bad_runs; logic [7:0] mb; bit ml; logic [2:0] cso;
    loopback = 1'b1;
    run_byte(8'hA5, 16'd0, 1'b0, ack_n, ack_cycles, rises, bad_runs, mb, ml, cso);
    checks++; if (ack_n != 17) begin errors++; $display("FAIL lb_ack_time: got %0d want 17", ack_n); end
    checks++; if (ack_cycles != 1) begin errors++; $display("FAIL lb_ack_width: got %0d want 1", ack_cycles); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL lb_data_out: got %h want a5", data_out); end
    checks++; if (rises != 8) begin errors++; $display("FAIL lb_sclk_pulses: got %0d want 8", rises); end
    checks++; if (bad_runs != 0) begin errors++; $display("FAIL lb_sclk_period: got %0d bad want 0", bad_runs); end
    checks++; if (mb !== 8'hA5) begin errors++; $display("FAIL lb_mosi_bits: got %h want a5", mb); end
  endtask

  task automatic test_divider();
    int ack_n, ack_cycles, rises, bad_runs; logic [7:0] mb; bit ml; logic [2:0] cso;
    loopback = 1'b1;
    run_byte(8'h40, 16'd3, 1'b0, ack_n, ack_cycles, rises, bad_runs, mb, ml, cso);
    checks++; if (ack_n != 65) begin errors++; $display("FAIL div_ack_time: got %0d want 65", ack_n); end
    checks++; if (bad_runs != 0) begin errors++; $display("FAIL div_half_period: got %0d bad want 0", bad_runs); end
    checks++; if (rises != 8) begin errors++; $display("FAIL div_sclk_pulses: got %0d want 8", rises); end
    checks++; if (mb !== 8'h40) begin errors++; $display("FAIL div_mosi_bits: got %h want 40", mb); end
    checks++; if (data_out !== 8'h40) begin errors++; $display("FAIL div_data_out: got %h want 40", data_out); end
  endtask

  task automatic test_receive();
    int ack_n, ack_cycles, rises, bad_runs; logic [7:0] mb; bit ml; logic [2:0] cso;
    loopback = 1'b0; slave_val = 8'h01;
    run_byte(8'hFF, 16'd1, 1'b0, ack_n, ack_cycles, rises, bad_runs, mb, ml, cso);
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL rx_data_out: got %h want 01", data_out); end
    checks++; if (ml !== 1'b0) begin errors++; $display("FAIL rx_mosi_high: got low=%b want 0", ml); end
    checks++; if (ack_n != 33) begin errors++; $display("FAIL rx_ack_time: got %0d want 33", ack_n); end
    loopback = 1'b1;
  endtask

  task automatic test_back_to_back();
    int a1, a2; logic m_idle, m_start; logic [7:0] d1;
    a1 = 0; a2 = 0; m_idle = 1'bx; m_start = 1'bx; d1 = 8'hxx;
    loopback = 1'b1;
    @(negedge sys_clk);
    data_in = 8'h3C; clk_div = 16'd0; wr_req = 1'b1;
    @(posedge sys_clk);
    for (int n = 1; n <= 80; n++) begin
      @(negedge sys_clk);
      if (wr_ack === 1'b1 && a1 == 0) begin
        a1 = n; d1 = data_out;
      end else if (wr_ack === 1'b1 && a2 == 0) begin
        a2 = n; wr_req = 1'b0;
      end
      if (a1 != 0 && n == a1 + 1) data_in = 8'h5A;
      if (a1 != 0 && n == a1 + 2) m_idle = spi_mosi;
      if (a1 != 0 && n == a1 + 3) m_start = spi_mosi;
      if (a2 != 0) break;
    end
    wr_req = 1'b0;
    checks++; if (a1 != 17) begin errors++; $display("FAIL b2b_first_ack: got %0d want 17", a1); end
    checks++; if (d1 !== 8'h3C) begin errors++; $display("FAIL b2b_first_data: got %h want 3c", d1); end
    checks++; if (a2 - a1 != 19) begin errors++; $display("FAIL b2b_spacing: got %0d want 19", a2 - a1); end
    checks++; if (m_idle !== 1'b1) begin errors++; $display("FAIL b2b_gap_mosi: got %b want 1", m_idle); end
    checks++; if (m_start !== 1'b0) begin errors++; $display("FAIL b2b_start_mosi: got %b want 0", m_start); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL b2b_second_data: got %h want 5a", data_out); end
  endtask

  task automatic test_reset_mid_byte();
    int tr, acks; logic prev; logic mosi_pre;
    tr = 0; acks = 0; prev = 1'b0; mosi_pre = 1'bx;
    loopback = 1'b1;
    @(negedge sys_clk);
    data_in = 8'h00; clk_div = 16'd1; wr_req = 1'b1;
    @(posedge sys_clk);
    for (int n = 1; n <= 100; n++) begin
      @(negedge sys_clk);
      if (spi_sclk !== prev) begin tr++; prev = spi_sclk; end
      if (tr == 9) break;
    end
    mosi_pre = spi_mosi;
    checks++; if (tr != 9) begin errors++; $display("FAIL rst_reach_edge9: got %0d want 9", tr); end
    checks++; if (mosi_pre !== 1'b0) begin errors++; $display("FAIL rst_pre_mosi: got %b want 0", mosi_pre); end
    wr_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b1) begin errors++; $display("FAIL rst_mid_mosi: got %b want 1", spi_mosi); end
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n: got %b want 1", spi_cs_n); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data_out: got %h want 00", data_out); end
    @(negedge sys_clk);
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge sys_clk);
      if (wr_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d want 0", acks); end
  endtask

  task automatic test_cs_div_latch();
    int ack_n, ack_cycles, rises, bad_runs; logic [7:0] mb; bit ml; logic [2:0] cso;
    loopback = 1'b1; nCS_ctrl = 1'b0;
    run_byte(8'h96, 16'd0, 1'b1, ack_n, ack_cycles, rises, bad_runs, mb, ml, cso);
    checks++; if (cso !== 3'b010) begin errors++; $display("FAIL cs_follow: got %b want 010", cso); end
    checks++; if (ack_n != 17) begin errors++; $display("FAIL cs_div_ack_time: got %0d want 17", ack_n); end
    checks++; if (bad_runs != 0) begin errors++; $display("FAIL cs_div_half_period: got %0d bad want 0", bad_runs); end
    checks++; if (data_out !== 8'h96) begin errors++; $display("FAIL cs_div_data_out: got %h want 96", data_out); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_divider();
    test_receive();
    test_back_to_back();
    test_reset_mid_byte();
    test_cs_div_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
